// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset sequencer and run supervisor.
// Releases per-stage resets one after another, counts run cycles, and halts
// on a datapath error or when the run-cycle budget is used up. A halt is
// sticky until clr restarts the release sequence. Every output is a flop.
module rst_seq_ctrl #(
  parameter int NUM_STG  = 3,
  parameter int HOLD_CYC = 2,
  parameter int MAX_CYC  = 100000,
  parameter int CNT_W    = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               err,
  input  logic               clr,
  output logic [NUM_STG-1:0] stg_rst,
  output logic               run,
  output logic               halt,
  output logic               halt_err,
  output logic               halt_tmo,
  output logic [CNT_W-1:0]   cyc_cnt
);

  // The hold counter only has to reach the edge that releases the last stage.
  localparam int SEQ_LEN = NUM_STG * HOLD_CYC;
  localparam int HOLD_W  = $clog2(SEQ_LEN + 1);

  localparam logic [HOLD_W-1:0] SEQ_END  = HOLD_W'(SEQ_LEN);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZRO = HOLD_W'(0);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_TMO  = CNT_W'(MAX_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZRO  = CNT_W'(0);

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_SEQ      = 3'd1,
    ST_RUN      = 3'd2,
    ST_HALT_ERR = 3'd3,
    ST_HALT_TMO = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [HOLD_W-1:0]  hold_r, hold_s;
  logic [HOLD_W-1:0]  hold_inc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [NUM_STG-1:0] stg_r, stg_s;
  logic [NUM_STG-1:0] seq_mask_s;
  logic               run_r, run_s;
  logic               halt_r, halt_s;
  logic               herr_r, herr_s;
  logic               htmo_r, htmo_s;

  assign hold_inc_s = hold_r + HOLD_ONE;

  // Stage k stays in reset until (k+1)*HOLD_CYC edges have passed since E0.
  always_comb begin
    seq_mask_s = {NUM_STG{1'b1}};
    for (int k = 0; k < NUM_STG; k++) begin
      seq_mask_s[k] = (hold_inc_s < HOLD_W'((k + 1) * HOLD_CYC));
    end
  end

  // Next state, counters and output values; rst low overrides everything.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    cnt_s   = cnt_r;
    stg_s   = {NUM_STG{1'b1}};
    run_s   = 1'b0;
    halt_s  = 1'b0;
    herr_s  = 1'b0;
    htmo_s  = 1'b0;
    if (!rst) begin
      state_s = ST_ASSERT;
      hold_s  = HOLD_ZRO;
      cnt_s   = CNT_ZRO;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          // This edge is E0: start releasing with every stage still held.
          state_s = ST_SEQ;
          hold_s  = HOLD_ZRO;
          cnt_s   = CNT_ZRO;
        end
        ST_SEQ: begin
          // err and clr are deliberately ignored while sequencing.
          if (hold_inc_s == SEQ_END) begin
            state_s = ST_RUN;
            hold_s  = HOLD_ZRO;
            cnt_s   = CNT_ZRO;
            stg_s   = {NUM_STG{1'b0}};
            run_s   = 1'b1;
          end else begin
            hold_s  = hold_inc_s;
            stg_s   = seq_mask_s;
          end
        end
        ST_RUN: begin
          // Error wins over a simultaneous timeout and freezes the count.
          if (err) begin
            state_s = ST_HALT_ERR;
            halt_s  = 1'b1;
            herr_s  = 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            state_s = ST_HALT_TMO;
            cnt_s   = CNT_TMO;
            halt_s  = 1'b1;
            htmo_s  = 1'b1;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
            stg_s   = {NUM_STG{1'b0}};
            run_s   = 1'b1;
          end
        end
        ST_HALT_ERR, ST_HALT_TMO: begin
          // Halts are sticky; clr makes this edge the new E0.
          if (clr) begin
            state_s = ST_SEQ;
            hold_s  = HOLD_ZRO;
            cnt_s   = CNT_ZRO;
          end else begin
            halt_s  = 1'b1;
            herr_s  = (state_r == ST_HALT_ERR);
            htmo_s  = (state_r == ST_HALT_TMO);
          end
        end
        default: begin
          state_s = ST_ASSERT;
          hold_s  = HOLD_ZRO;
          cnt_s   = CNT_ZRO;
        end
      endcase
    end
  end

  // State, counters and every output flop update together on the clock edge.
  always_ff @(posedge clk) begin
    state_r <= state_s;
    hold_r  <= hold_s;
    cnt_r   <= cnt_s;
    stg_r   <= stg_s;
    run_r   <= run_s;
    halt_r  <= halt_s;
    herr_r  <= herr_s;
    htmo_r  <= htmo_s;
  end

  assign stg_rst  = stg_r;
  assign run      = run_r;
  assign halt     = halt_r;
  assign halt_err = herr_r;
  assign halt_tmo = htmo_r;
  assign cyc_cnt  = cnt_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed scenarios plus randomized traffic for
// rst_seq_ctrl, every cycle compared against a phase/age reference model.
module tb_rst_seq_ctrl;

  localparam int NS = 3;
  localparam int H  = 2;
  localparam int MX = 16;
  localparam int CW = 5;

  localparam int P_ASSERT = 0;
  localparam int P_SEQ    = 1;
  localparam int P_RUN    = 2;
  localparam int P_HERR   = 3;
  localparam int P_HTMO   = 4;

  logic          clk;
  logic          rst;
  logic          err;
  logic          clr;
  logic [NS-1:0] stg_rst;
  logic          run;
  logic          halt;
  logic          halt_err;
  logic          halt_tmo;
  logic [CW-1:0] cyc_cnt;

  int checks;
  int errors;

  // Reference model: phase, edges since E0, run-cycle count.
  int m_phase;
  int m_age;
  int m_cyc;

  rst_seq_ctrl #(
    .NUM_STG (NS),
    .HOLD_CYC(H),
    .MAX_CYC (MX),
    .CNT_W   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .err     (err),
    .clr     (clr),
    .stg_rst (stg_rst),
    .run     (run),
    .halt    (halt),
    .halt_err(halt_err),
    .halt_tmo(halt_tmo),
    .cyc_cnt (cyc_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs sampled there.
  task automatic model_edge(input logic r, input logic e, input logic c);
    if (!r) begin
      m_phase = P_ASSERT;
      m_age   = 0;
      m_cyc   = 0;
    end else if (m_phase == P_ASSERT) begin
      m_phase = P_SEQ;
      m_age   = 0;
      m_cyc   = 0;
    end else if (m_phase == P_SEQ) begin
      m_age = m_age + 1;
      if (m_age == NS * H) begin
        m_phase = P_RUN;
        m_cyc   = 0;
      end
    end else if (m_phase == P_RUN) begin
      if (e) m_phase = P_HERR;
      else if (m_cyc == MX - 1) begin
        m_phase = P_HTMO;
        m_cyc   = MX;
      end else m_cyc = m_cyc + 1;
    end else begin
      if (c) begin
        m_phase = P_SEQ;
        m_age   = 0;
        m_cyc   = 0;
      end
    end
  endtask

  function automatic logic [NS-1:0] exp_stg();
    logic [NS-1:0] v;
    v = {NS{1'b1}};
    if (m_phase == P_RUN) v = {NS{1'b0}};
    else if (m_phase == P_SEQ) begin
      for (int k = 0; k < NS; k++) v[k] = (m_age < (k + 1) * H);
    end
    return v;
  endfunction

  // Drive inputs, take one edge, then compare every output 1 unit later.
  task automatic step(input logic r, input logic e, input logic c);
    rst = r;
    err = e;
    clr = c;
    @(posedge clk);
    model_edge(r, e, c);
    #1;
    chk("stg_rst",  32'(stg_rst),  32'(exp_stg()));
    chk("run",      32'(run),      32'(m_phase == P_RUN));
    chk("halt",     32'(halt),     32'(m_phase == P_HERR || m_phase == P_HTMO));
    chk("halt_err", 32'(halt_err), 32'(m_phase == P_HERR));
    chk("halt_tmo", 32'(halt_tmo), 32'(m_phase == P_HTMO));
    chk("cyc_cnt",  32'(cyc_cnt),  32'(m_cyc));
  endtask

  // Step with idle inputs until the model reaches the given phase (bounded).
  task automatic run_to_phase(input int ph, input string tag);
    for (int i = 0; i < 60 && m_phase != ph; i++) step(1'b1, 1'b0, 1'b0);
    chk(tag, 32'(m_phase == ph), 32'd1);
  endtask

  // Step in RUN with idle inputs until the count reaches n (bounded).
  task automatic run_to_cyc(input int n, input string tag);
    for (int i = 0; i < 60 && !(m_phase == P_RUN && m_cyc == n); i++) step(1'b1, 1'b0, 1'b0);
    chk(tag, 32'(m_phase == P_RUN && m_cyc == n), 32'd1);
  endtask

  initial begin
    int lat;
    int errp;
    checks  = 0;
    errors  = 0;
    m_phase = P_ASSERT;
    m_age   = 0;
    m_cyc   = 0;
    rst = 1'b0;
    err = 1'b0;
    clr = 1'b0;
    #1;

    // Reset sequence: rst low 3 cycles, then count edges from E0 to RUN.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("rst_stg", 32'(stg_rst), 32'h7);
    step(1'b1, 1'b0, 1'b0);
    lat = 0;
    for (int i = 0; i < 20 && run !== 1'b1; i++) begin
      step(1'b1, 1'b0, 1'b0);
      lat++;
    end
    chk("rst_to_run_edges", 32'(lat), 32'd6);
    chk("run_entry_cnt", 32'(cyc_cnt), 32'd0);

    // Timeout: idle through RUN, then random err in the halt is ignored.
    run_to_phase(P_HTMO, "reach_tmo");
    chk("tmo_cnt", 32'(cyc_cnt), 32'd16);
    chk("tmo_flag", 32'(halt_tmo), 32'd1);
    repeat (20) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    chk("tmo_stable_cnt", 32'(cyc_cnt), 32'd16);

    // clr held 3 cycles restarts once; random err/clr during SEQ ignored.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    chk("clr_held_stg", 32'(stg_rst), 32'h6);
    for (int i = 0; i < 20 && m_phase == P_SEQ; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("seq_ignores_inputs", 32'(m_phase == P_RUN && run === 1'b1), 32'd1);

    // Error halt at cyc_cnt 5 with random clr during RUN, then 1-cycle clr.
    for (int i = 0; i < 20 && m_cyc != 5; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'b0);
    chk("err_halt", 32'(halt_err), 32'd1);
    chk("err_cnt", 32'(cyc_cnt), 32'd5);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("restart_stg", 32'(stg_rst), 32'h6);

    // Simultaneous err and timeout: err wins, count holds at 15.
    run_to_cyc(MX - 1, "reach_cnt15");
    step(1'b1, 1'b1, 1'b0);
    chk("simul_herr", 32'(halt_err), 32'd1);
    chk("simul_htmo", 32'(halt_tmo), 32'd0);
    chk("simul_cnt", 32'(cyc_cnt), 32'd15);

    // Reset mid-sequence and mid-run.
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("midseq_rst_stg", 32'(stg_rst), 32'h7);
    run_to_cyc(4, "reach_cnt4");
    step(1'b0, 1'b0, 1'b0);
    chk("midrun_rst_cnt", 32'(cyc_cnt), 32'd0);
    chk("midrun_rst_run", 32'(run), 32'd0);
    run_to_phase(P_RUN, "rerun_after_rst");

    // Randomized traffic, alternating error-free and error-prone blocks.
    for (int b = 0; b < 8; b++) begin
      errp = (b % 2 == 0) ? 0 : 6;
      for (int i = 0; i < 50; i++) begin
        step(1'($urandom_range(0, 24) != 0),
             (errp != 0) ? 1'($urandom_range(0, errp - 1) == 0) : 1'b0,
             1'($urandom_range(0, 4) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Synthesizable reset sequencer and run supervisor for the processor datapath. It releases a set of per-stage resets one after another, then counts run cycles. It halts the design on an error flag or when a cycle budget is exhausted. It sits between the board/bench reset source and the sub-blocks (fetch, decode, memory, etc.), and replaces ad-hoc reset/watchdog logic with one controller.

## Interface
Parameters:
- NUM_STG, 3: number of staged reset outputs (>= 1).
- HOLD_CYC, 2: cycles between consecutive stage releases (>= 1).
- MAX_CYC, 100000: run-cycle budget before timeout halt (>= 1).
- CNT_W, 17: width of cycle counter; must satisfy 2^CNT_W > MAX_CYC.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- err  in  1  error flag from datapath, sampled only in RUN.
- clr  in  1  restart request, honoured only in a halt state.
- stg_rst  out  NUM_STG  per-stage resets, active-high; bit 0 released first.
- run  out  1  high while in RUN.
- halt  out  1  high in either halt state.
- halt_err  out  1  high in HALT_ERR.
- halt_tmo  out  1  high in HALT_TMO.
- cyc_cnt  out  CNT_W  run-cycle count.

## Operation
- States: ASSERT, SEQ, RUN, HALT_ERR, HALT_TMO. All outputs are registered and decode directly from state and counters.
- rst low at any edge, in any state, including mid-sequence or mid-run:
  - next state is ASSERT;
  - stg_rst = all 1s; run = halt = halt_err = halt_tmo = 0;
  - cyc_cnt = 0; internal hold counter = 0.
- ASSERT to SEQ on the first edge at which rst is sampled high. Call this edge E0.
- SEQ:
  - The hold counter counts edges.
  - stg_rst[k] clears at edge E0 + (k+1)*HOLD_CYC.
  - Released bits stay low; unreleased bits stay high.
  - err and clr are ignored.
- SEQ to RUN on the edge that clears stg_rst[NUM_STG-1], which is E0 + NUM_STG*HOLD_CYC. On that edge run = 1 and cyc_cnt = 0.
- RUN:
  - cyc_cnt increments by 1 on each edge.
  - stg_rst stays all 0s.
- Error halt: err = 1 sampled in RUN moves to HALT_ERR on that edge.
  - run = 0, halt = halt_err = 1.
  - stg_rst = all 1s.
  - cyc_cnt holds its value and is not incremented on that edge.
- Timeout halt: cyc_cnt == MAX_CYC-1 sampled in RUN with err = 0 moves to HALT_TMO on that edge.
  - cyc_cnt becomes MAX_CYC.
  - run = 0, halt = halt_tmo = 1.
  - stg_rst = all 1s.
- Simultaneous err and timeout: err has priority. Next state is HALT_ERR, halt_tmo stays 0, cyc_cnt holds.
- Halt states:
  - Sticky; cyc_cnt frozen.
  - err ignored.
  - clr = 1 moves to SEQ on that edge. That edge becomes the new E0: hold counter = 0, cyc_cnt = 0, stg_rst = all 1s, halt flags = 0.
- clr in ASSERT, SEQ or RUN has no effect.
- rst low takes priority over clr, err and timeout.

## Timing
- All inputs are sampled at the rising edge; every output changes only at a rising edge. There are no combinational input-to-output paths.
- Reset-to-run latency is NUM_STG*HOLD_CYC edges after E0. With defaults that is 6 edges.
- Error detect to halt is 1 edge: halt is visible in the cycle after the err-sampling edge.
- RUN lasts exactly MAX_CYC edges before a timeout halt, absent err.
- clr is level-sampled; holding it for several cycles in a halt state restarts only once, because SEQ ignores clr.
- cyc_cnt never wraps; its maximum value is MAX_CYC.

## Test plan
- **Reset sequence** (NUM_STG=3, HOLD_CYC=2): rst low 3 cycles, then high.
  - stg_rst = 111 until E0+2, then 110 at E0+2, 100 at E0+4, 000 at E0+6.
  - run = 1 at E0+6, cyc_cnt = 0 there.
- **Timeout** (MAX_CYC=16): hold err = 0 after RUN entry.
  - cyc_cnt reaches 15, then halt_tmo = 1 with cyc_cnt = 16.
  - run = 0, stg_rst = 111, values stable for 20 further cycles.
- **Error halt**: pulse err for 1 cycle when cyc_cnt = 5.
  - Next cycle: halt_err = 1, cyc_cnt = 5, stg_rst = 111.
  - A 1-cycle clr then restarts the sequence: stg_rst = 110 two edges later.
- **Ignored inputs**: pulse err during SEQ and clr during RUN.
  - No state change; the sequence timing is identical to the reset-sequence scenario.
- **Simultaneous events**: err = 1 on the edge where cyc_cnt = 15 (MAX_CYC=16).
  - halt_err = 1, halt_tmo = 0, cyc_cnt = 15.
- **Reset mid-operation**: rst low for 1 cycle during SEQ, and again during RUN.
  - All outputs return to reset values (stg_rst = 111, cyc_cnt = 0) on that edge.
  - The sequence restarts from the new E0.
